// File: rtl/rob_multiport_pkg.sv
// Shared encodings for the multi-port reorder buffer: entry types, store widths
// and the default geometry.
package rob_multiport_pkg;

    localparam int DEFAULT_DEPTH  = 32;
    localparam int DEFAULT_NUM_WB = 3;

    typedef enum logic [2:0] {
        ROB_REG    = 3'd0,
        ROB_JALR   = 3'd1,
        ROB_SB     = 3'd2,
        ROB_SH     = 3'd3,
        ROB_SW     = 3'd4,
        ROB_BRANCH = 3'd5,
        ROB_EXIT   = 3'd6
    } rob_type_e;

    typedef enum logic [1:0] {
        ST_BYTE = 2'd0,
        ST_HALF = 2'd1,
        ST_WORD = 2'd2
    } st_type_e;

    function automatic logic is_store(input logic [2:0] t);
        return (t == ROB_SB) || (t == ROB_SH) || (t == ROB_SW);
    endfunction

    function automatic logic [1:0] store_type(input logic [2:0] t);
        logic [1:0] s;
        case (t)
            ROB_SB:  s = ST_BYTE;
            ROB_SH:  s = ST_HALF;
            default: s = ST_WORD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rob_wb_select.sv
// Priority match of all writeback channels against one entry id; the
// highest-numbered matching channel supplies the data.
module rob_wb_select #(
    parameter int NUM_WB = 3,
    parameter int IDX_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic [NUM_WB-1:0]        valid_i,
    input  logic [NUM_WB*IDX_W-1:0]  id_i,
    input  logic [NUM_WB*DATA_W-1:0] data_i,
    input  logic [IDX_W-1:0]         match_id_i,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        data_o
);

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (valid_i[k] && (id_i[k*IDX_W +: IDX_W] == match_id_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// Parametrised reorder buffer with multiple writeback channels, bypassed operand
// queries, a valid/ready store commit port and a sticky halt.
module rob_multiport
    import rob_multiport_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NUM_WB = DEFAULT_NUM_WB,
    parameter int XLEN   = 32,
    parameter int REG_W  = 5,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    dec_valid,
    input  logic [2:0]              dec_type,
    input  logic [REG_W-1:0]        dec_dest,
    input  logic [XLEN-1:0]         dec_value,
    input  logic                    dec_done,
    input  logic [XLEN-1:0]         dec_instr_addr,
    input  logic [XLEN-1:0]         dec_pred_addr,
    input  logic                    dec_pred_taken,
    output logic [IDX_W-1:0]        alloc_id,
    output logic                    full,
    output logic                    empty,
    output logic [IDX_W:0]          count,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*IDX_W-1:0] wb_id,
    input  logic [NUM_WB*XLEN-1:0]  wb_value,
    input  logic [NUM_WB*XLEN-1:0]  wb_addr,
    input  logic [IDX_W-1:0]        qry_id0,
    input  logic [IDX_W-1:0]        qry_id1,
    output logic                    qry_done0,
    output logic                    qry_done1,
    output logic [XLEN-1:0]         qry_value0,
    output logic [XLEN-1:0]         qry_value1,
    output logic                    rf_valid,
    output logic [REG_W-1:0]        rf_rd,
    output logic [XLEN-1:0]         rf_value,
    output logic [IDX_W-1:0]        rf_id,
    output logic                    st_valid,
    input  logic                    st_ready,
    output logic [1:0]              st_type,
    output logic [XLEN-1:0]         st_addr,
    output logic [XLEN-1:0]         st_data,
    output logic                    pred_valid,
    output logic [XLEN-1:0]         pred_addr,
    output logic                    pred_taken,
    output logic                    flush,
    output logic [XLEN-1:0]         redirect_addr,
    output logic                    halt
);

    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d, nextHead, stIdx;
    logic [IDX_W:0]   count_q, count_d;
    logic [DEPTH-1:0] busy_q, busy_d, done_q, done_d;

    logic [2:0]       type_q      [DEPTH];
    logic [REG_W-1:0] dest_q      [DEPTH];
    logic [XLEN-1:0]  value_q     [DEPTH];
    logic [XLEN-1:0]  addr_q      [DEPTH];
    logic [XLEN-1:0]  instrAddr_q [DEPTH];
    logic [XLEN-1:0]  predAddr_q  [DEPTH];
    logic [DEPTH-1:0] predTaken_q;

    logic             rfValid_q, rfValid_d, stValid_q, stValid_d;
    logic             predValid_q, predValid_d, predTaken_q2, predTaken_d;
    logic             flush_q, flush_d, halt_q, halt_d;
    logic [REG_W-1:0] rfRd_q, rfRd_d;
    logic [IDX_W-1:0] rfId_q, rfId_d;
    logic [1:0]       stType_q, stType_d;
    logic [XLEN-1:0]  rfValue_q, rfValue_d, stAddr_q, stAddr_d, stData_q, stData_d;
    logic [XLEN-1:0]  predAddr_q2, predAddr_d, redirect_q, redirect_d;

    logic active, allocEn, retire, headReady, isFull;
    logic [XLEN-1:0] headValue, headPcPlus4;

    logic [NUM_WB*2*XLEN-1:0] wbAddrValue;
    logic [DEPTH-1:0]         wbHit, wbWrite;
    logic [2*XLEN-1:0]        wbData [DEPTH];
    logic                     qHit0, qHit1;
    logic [XLEN-1:0]          qData0, qData1;

    // Writeback channels carry {addr, value} together so one selector resolves both.
    always_comb begin
        wbAddrValue = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            wbAddrValue[k*2*XLEN +: 2*XLEN] = {wb_addr[k*XLEN +: XLEN], wb_value[k*XLEN +: XLEN]};
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_wb
        rob_wb_select #(.NUM_WB(NUM_WB), .IDX_W(IDX_W), .DATA_W(2*XLEN)) u_sel (
            .valid_i   (wb_valid),
            .id_i      (wb_id),
            .data_i    (wbAddrValue),
            .match_id_i(IDX_W'(i)),
            .hit_o     (wbHit[i]),
            .data_o    (wbData[i])
        );
    end

    rob_wb_select #(.NUM_WB(NUM_WB), .IDX_W(IDX_W), .DATA_W(XLEN)) u_qry0 (
        .valid_i(wb_valid), .id_i(wb_id), .data_i(wb_value),
        .match_id_i(qry_id0), .hit_o(qHit0), .data_o(qData0)
    );

    rob_wb_select #(.NUM_WB(NUM_WB), .IDX_W(IDX_W), .DATA_W(XLEN)) u_qry1 (
        .valid_i(wb_valid), .id_i(wb_id), .data_i(wb_value),
        .match_id_i(qry_id1), .hit_o(qHit1), .data_o(qData1)
    );

    assign qry_done0  = (busy_q[qry_id0] && done_q[qry_id0]) || qHit0;
    assign qry_done1  = (busy_q[qry_id1] && done_q[qry_id1]) || qHit1;
    assign qry_value0 = qHit0 ? qData0 : value_q[qry_id0];
    assign qry_value1 = qHit1 ? qData1 : value_q[qry_id1];

    assign isFull      = (count_q == (IDX_W+1)'(DEPTH));
    assign active      = rdy_in && !flush_q;
    assign allocEn     = active && dec_valid && !isFull;
    assign wbWrite     = active ? (busy_q & wbHit) : '0;
    assign nextHead    = head_q + 1'b1;
    assign stIdx       = stValid_q ? nextHead : head_q;
    assign headReady   = busy_q[head_q] && done_q[head_q];
    assign headValue   = value_q[head_q];
    assign headPcPlus4 = instrAddr_q[head_q] + XLEN'(4);

    // Commit engine: a pending store blocks the head until accepted, and on
    // acceptance an already-done store behind it is presented without a gap.
    always_comb begin
        rfValid_d   = 1'b0;
        rfRd_d      = rfRd_q;
        rfValue_d   = rfValue_q;
        rfId_d      = rfId_q;
        stValid_d   = stValid_q;
        stType_d    = stType_q;
        stAddr_d    = stAddr_q;
        stData_d    = stData_q;
        predValid_d = 1'b0;
        predAddr_d  = predAddr_q2;
        predTaken_d = predTaken_q2;
        flush_d     = flush_q;
        redirect_d  = redirect_q;
        halt_d      = halt_q;
        retire      = 1'b0;
        if (rdy_in) begin
            if (flush_q) begin
                flush_d = 1'b0;
            end else if (stValid_q) begin
                if (st_ready) begin
                    retire    = 1'b1;
                    stValid_d = busy_q[nextHead] && done_q[nextHead] && is_store(type_q[nextHead]);
                end
            end else if (!halt_q && headReady) begin
                case (type_q[head_q])
                    ROB_REG: begin
                        rfValid_d = 1'b1;
                        rfRd_d    = dest_q[head_q];
                        rfValue_d = headValue;
                        rfId_d    = head_q;
                        retire    = 1'b1;
                    end
                    ROB_JALR: begin
                        rfValid_d = 1'b1;
                        rfRd_d    = dest_q[head_q];
                        rfValue_d = headPcPlus4;
                        rfId_d    = head_q;
                        retire    = 1'b1;
                        if (headValue != predAddr_q[head_q]) begin
                            flush_d    = 1'b1;
                            redirect_d = headValue;
                        end
                    end
                    ROB_SB, ROB_SH, ROB_SW: begin
                        stValid_d = 1'b1;
                    end
                    ROB_BRANCH: begin
                        predValid_d = 1'b1;
                        predAddr_d  = instrAddr_q[head_q];
                        predTaken_d = headValue[0];
                        retire      = 1'b1;
                        if (headValue[0] != predTaken_q[head_q]) begin
                            flush_d    = 1'b1;
                            redirect_d = headValue[0] ? predAddr_q[head_q] : headPcPlus4;
                        end
                    end
                    ROB_EXIT: begin
                        halt_d = 1'b1;
                        retire = 1'b1;
                    end
                    default: retire = 1'b1;
                endcase
            end
            if (stValid_d && !(stValid_q && !st_ready)) begin
                stType_d = store_type(type_q[stIdx]);
                stAddr_d = addr_q[stIdx];
                stData_d = value_q[stIdx];
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = done_q | wbWrite;
        if (rdy_in && flush_q) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            busy_d  = '0;
        end else begin
            head_d  = head_q + IDX_W'(retire);
            tail_d  = tail_q + IDX_W'(allocEn);
            count_d = count_q + (IDX_W+1)'(allocEn) - (IDX_W+1)'(retire);
            if (retire) busy_d[head_q] = 1'b0;
            if (allocEn) begin
                busy_d[tail_q] = 1'b1;
                done_d[tail_q] = dec_done;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            busy_q       <= '0;
            done_q       <= '0;
            rfValid_q    <= 1'b0;
            rfRd_q       <= '0;
            rfValue_q    <= '0;
            rfId_q       <= '0;
            stValid_q    <= 1'b0;
            stType_q     <= '0;
            stAddr_q     <= '0;
            stData_q     <= '0;
            predValid_q  <= 1'b0;
            predAddr_q2  <= '0;
            predTaken_q2 <= 1'b0;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
            halt_q       <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rfValid_q    <= rfValid_d;
            rfRd_q       <= rfRd_d;
            rfValue_q    <= rfValue_d;
            rfId_q       <= rfId_d;
            stValid_q    <= stValid_d;
            stType_q     <= stType_d;
            stAddr_q     <= stAddr_d;
            stData_q     <= stData_d;
            predValid_q  <= predValid_d;
            predAddr_q2  <= predAddr_d;
            predTaken_q2 <= predTaken_d;
            flush_q      <= flush_d;
            redirect_q   <= redirect_d;
            halt_q       <= halt_d;
        end
    end

    // Entry payload needs no reset: busy/done gate every use of it.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (allocEn && (tail_q == IDX_W'(i))) begin
                type_q[i]      <= dec_type;
                dest_q[i]      <= dec_dest;
                value_q[i]     <= dec_value;
                addr_q[i]      <= '0;
                instrAddr_q[i] <= dec_instr_addr;
                predAddr_q[i]  <= dec_pred_addr;
                predTaken_q[i] <= dec_pred_taken;
            end else if (wbWrite[i]) begin
                value_q[i] <= wbData[i][XLEN-1:0];
                if (is_store(type_q[i])) addr_q[i] <= wbData[i][2*XLEN-1:XLEN];
            end
        end
    end

    assign alloc_id      = tail_q;
    assign full          = isFull;
    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign rf_valid      = rfValid_q && rdy_in;
    assign rf_rd         = rfRd_q;
    assign rf_value      = rfValue_q;
    assign rf_id         = rfId_q;
    assign st_valid      = stValid_q;
    assign st_type       = stType_q;
    assign st_addr       = stAddr_q;
    assign st_data       = stData_q;
    assign pred_valid    = predValid_q && rdy_in;
    assign pred_addr     = predAddr_q2;
    assign pred_taken    = predTaken_q2;
    assign flush         = flush_q && rdy_in;
    assign redirect_addr = redirect_q;
    assign halt          = halt_q;

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: fill/full, writeback priority and bypass,
// register/store/branch/jalr commit, flush, halt and the global stall.
module tb_rob_multiport;

   localparam logic [2:0] T_REG = 3'd0, T_JALR = 3'd1, T_SB = 3'd2, T_SH = 3'd3,
                          T_SW = 3'd4, T_BRANCH = 3'd5, T_EXIT = 3'd6;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        dec_valid, dec_done, dec_pred_taken;
   logic [2:0]  dec_type;
   logic [4:0]  dec_dest;
   logic [31:0] dec_value, dec_instr_addr, dec_pred_addr;
   logic [4:0]  alloc_id;
   logic        full, empty;
   logic [5:0]  count;
   logic [2:0]  wb_valid;
   logic [14:0] wb_id;
   logic [95:0] wb_value, wb_addr;
   logic [4:0]  qry_id0, qry_id1;
   logic        qry_done0, qry_done1;
   logic [31:0] qry_value0, qry_value1;
   logic        rf_valid;
   logic [4:0]  rf_rd, rf_id;
   logic [31:0] rf_value;
   logic        st_valid, st_ready;
   logic [1:0]  st_type;
   logic [31:0] st_addr, st_data;
   logic        pred_valid, pred_taken, flush, halt;
   logic [31:0] pred_addr, redirect_addr;

   int vectors = 0;
   int errors  = 0;

   always #5 clk_in = ~clk_in;

   rob_multiport dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .dec_valid(dec_valid), .dec_type(dec_type), .dec_dest(dec_dest),
      .dec_value(dec_value), .dec_done(dec_done), .dec_instr_addr(dec_instr_addr),
      .dec_pred_addr(dec_pred_addr), .dec_pred_taken(dec_pred_taken),
      .alloc_id(alloc_id), .full(full), .empty(empty), .count(count),
      .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value), .wb_addr(wb_addr),
      .qry_id0(qry_id0), .qry_id1(qry_id1), .qry_done0(qry_done0), .qry_done1(qry_done1),
      .qry_value0(qry_value0), .qry_value1(qry_value1),
      .rf_valid(rf_valid), .rf_rd(rf_rd), .rf_value(rf_value), .rf_id(rf_id),
      .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
      .st_addr(st_addr), .st_data(st_data),
      .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_taken(pred_taken),
      .flush(flush), .redirect_addr(redirect_addr), .halt(halt)
   );

   // Advance one clock and settle past the edge before sampling
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Quiet all inputs so each scenario starts from a known stimulus
   task automatic idleInputs();
      rdy_in = 1'b1; dec_valid = 1'b0; dec_type = T_REG; dec_dest = '0;
      dec_value = '0; dec_done = 1'b0; dec_instr_addr = '0; dec_pred_addr = '0;
      dec_pred_taken = 1'b0; wb_valid = '0; wb_id = '0; wb_value = '0; wb_addr = '0;
      qry_id0 = '0; qry_id1 = '0; st_ready = 1'b0;
   endtask

   // Allocation fields for one decoded instruction
   task automatic applyStimulus(input logic [2:0] t, input logic [4:0] d, input logic [31:0] v,
                                input logic dn, input logic [31:0] pc, input logic [31:0] pa,
                                input logic pt);
      dec_valid = 1'b1; dec_type = t; dec_dest = d; dec_value = v; dec_done = dn;
      dec_instr_addr = pc; dec_pred_addr = pa; dec_pred_taken = pt;
   endtask

   task automatic doReset();
      idleInputs();
      rst_in = 1'b1;
      tick();
      tick();
      rst_in = 1'b0;
   endtask

   // Reset values of flags and outputs
   task automatic test_reset();
      doReset();
      vectors++; if (count !== 6'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
      vectors++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: empty=%b full=%b want 1 0", empty, full); end
      vectors++; if (alloc_id !== 5'd0) begin errors++; $display("[TB] FAIL reset_alloc_id: got %0d want 0", alloc_id); end
      vectors++; if ({rf_valid, pred_valid, flush, st_valid, halt} !== 5'b0) begin errors++; $display("[TB] FAIL reset_pulses: got %b want 00000", {rf_valid, pred_valid, flush, st_valid, halt}); end
      vectors++; if (rf_value !== 32'd0 || st_addr !== 32'd0 || redirect_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_data: rf=%h st=%h redir=%h want 0", rf_value, st_addr, redirect_addr); end
   endtask

   // Fill to capacity, overflow attempt, writeback priority and bypass, then first retire
   task automatic test_fill_and_writeback();
      doReset();
      for (int i = 0; i < 32; i++) begin
         applyStimulus(T_REG, 5'(i + 1), 32'd0, 1'b0, 32'(i * 4), 32'd0, 1'b0);
         tick();
      end
      vectors++; if (full !== 1'b1 || count !== 6'd32) begin errors++; $display("[TB] FAIL fill_full: full=%b count=%0d want 1 32", full, count); end
      vectors++; if (alloc_id !== 5'd0) begin errors++; $display("[TB] FAIL fill_tail_wrap: got %0d want 0", alloc_id); end
      tick();
      vectors++; if (count !== 6'd32 || alloc_id !== 5'd0) begin errors++; $display("[TB] FAIL overflow_ignored: count=%0d alloc=%0d want 32 0", count, alloc_id); end
      dec_valid = 1'b0;
      qry_id0 = 5'd5; qry_id1 = 5'd7;
      #1;
      vectors++; if (qry_done0 !== 1'b0) begin errors++; $display("[TB] FAIL qry_not_done: got %b want 0", qry_done0); end
      wb_valid = 3'b111;
      wb_id[0 +: 5] = 5'd5;  wb_value[0 +: 32]  = 32'h11;
      wb_id[5 +: 5] = 5'd7;  wb_value[32 +: 32] = 32'h33;
      wb_id[10 +: 5] = 5'd5; wb_value[64 +: 32] = 32'h22;
      #1;
      vectors++; if (qry_done0 !== 1'b1 || qry_value0 !== 32'h22) begin errors++; $display("[TB] FAIL wb_priority_bypass: done=%b value=%h want 1 00000022", qry_done0, qry_value0); end
      vectors++; if (qry_done1 !== 1'b1 || qry_value1 !== 32'h33) begin errors++; $display("[TB] FAIL bypass_port1: done=%b value=%h want 1 00000033", qry_done1, qry_value1); end
      tick();
      wb_valid = '0;
      #1;
      vectors++; if (qry_done0 !== 1'b1 || qry_value0 !== 32'h22) begin errors++; $display("[TB] FAIL wb_priority_stored: done=%b value=%h want 1 00000022", qry_done0, qry_value0); end
      wb_valid = 3'b001; wb_id[0 +: 5] = 5'd0; wb_value[0 +: 32] = 32'hABCD;
      tick();
      wb_valid = '0;
      vectors++; if (rf_valid !== 1'b0) begin errors++; $display("[TB] FAIL wb_commit_early: rf_valid=%b want 0", rf_valid); end
      tick();
      vectors++; if (rf_valid !== 1'b1 || rf_value !== 32'hABCD || rf_rd !== 5'd1 || rf_id !== 5'd0) begin errors++; $display("[TB] FAIL reg_commit: v=%b val=%h rd=%0d id=%0d want 1 0000abcd 1 0", rf_valid, rf_value, rf_rd, rf_id); end
      vectors++; if (count !== 6'd31 || full !== 1'b0 || alloc_id !== 5'd0) begin errors++; $display("[TB] FAIL reg_commit_count: count=%0d full=%b alloc=%0d want 31 0 0", count, full, alloc_id); end
      tick();
      vectors++; if (rf_valid !== 1'b0) begin errors++; $display("[TB] FAIL rf_pulse_width: rf_valid=%b want 0", rf_valid); end
      applyStimulus(T_REG, 5'd9, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      tick();
      dec_valid = 1'b0;
      vectors++; if (alloc_id !== 5'd1 || count !== 6'd32) begin errors++; $display("[TB] FAIL alloc_after_wrap: alloc=%0d count=%0d want 1 32", alloc_id, count); end
   endtask

   // Store held under backpressure, then a done register behind it
   task automatic test_store_handshake();
      doReset();
      applyStimulus(T_SW, 5'd0, 32'd0, 1'b0, 32'h80, 32'd0, 1'b0);
      tick();
      applyStimulus(T_REG, 5'd3, 32'h55, 1'b1, 32'h84, 32'd0, 1'b0);
      wb_valid = 3'b010; wb_id[5 +: 5] = 5'd0;
      wb_value[32 +: 32] = 32'hDEADBEEF; wb_addr[32 +: 32] = 32'h1000;
      tick();
      idleInputs();
      tick();
      vectors++; if (st_valid !== 1'b1 || st_addr !== 32'h1000 || st_data !== 32'hDEADBEEF || st_type !== 2'd2) begin errors++; $display("[TB] FAIL store_present: v=%b a=%h d=%h t=%0d want 1 00001000 deadbeef 2", st_valid, st_addr, st_data, st_type); end
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++; if (st_valid !== 1'b1 || st_addr !== 32'h1000 || st_data !== 32'hDEADBEEF || count !== 6'd2) begin errors++; $display("[TB] FAIL store_hold: cycle=%0d v=%b a=%h d=%h count=%0d want 1 00001000 deadbeef 2", c, st_valid, st_addr, st_data, count); end
      end
      st_ready = 1'b1;
      tick();
      st_ready = 1'b0;
      vectors++; if (st_valid !== 1'b0 || count !== 6'd1 || rf_valid !== 1'b0) begin errors++; $display("[TB] FAIL store_retire: v=%b count=%0d rf=%b want 0 1 0", st_valid, count, rf_valid); end
      tick();
      vectors++; if (rf_valid !== 1'b1 || rf_value !== 32'h55 || rf_rd !== 5'd3 || rf_id !== 5'd1 || empty !== 1'b1) begin errors++; $display("[TB] FAIL reg_after_store: v=%b val=%h rd=%0d id=%0d empty=%b want 1 00000055 3 1 1", rf_valid, rf_value, rf_rd, rf_id, empty); end
   endtask

   // Two done stores back to back keep st_valid high across the handoff
   task automatic test_back_to_back();
      doReset();
      applyStimulus(T_SB, 5'd0, 32'hAA, 1'b1, 32'd0, 32'd0, 1'b0);
      tick();
      applyStimulus(T_SH, 5'd0, 32'hBBBB, 1'b1, 32'd4, 32'd0, 1'b0);
      tick();
      dec_valid = 1'b0; st_ready = 1'b1;
      vectors++; if (st_valid !== 1'b1 || st_type !== 2'd0 || st_data !== 32'hAA) begin errors++; $display("[TB] FAIL b2b_first: v=%b t=%0d d=%h want 1 0 000000aa", st_valid, st_type, st_data); end
      tick();
      vectors++; if (st_valid !== 1'b1 || st_type !== 2'd1 || st_data !== 32'hBBBB || count !== 6'd1) begin errors++; $display("[TB] FAIL b2b_second: v=%b t=%0d d=%h count=%0d want 1 1 0000bbbb 1", st_valid, st_type, st_data, count); end
      tick();
      st_ready = 1'b0;
      vectors++; if (st_valid !== 1'b0 || count !== 6'd0) begin errors++; $display("[TB] FAIL b2b_done: v=%b count=%0d want 0 0", st_valid, count); end
   endtask

   // Mispredicted branch with younger entries flushes everything
   task automatic test_branch_flush();
      doReset();
      applyStimulus(T_BRANCH, 5'd0, 32'd0, 1'b0, 32'h40, 32'h100, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(T_REG, 5'(i + 1), 32'd0, 1'b0, 32'(68 + i * 4), 32'd0, 1'b0);
         tick();
      end
      dec_valid = 1'b0;
      vectors++; if (count !== 6'd5) begin errors++; $display("[TB] FAIL branch_fill: count=%0d want 5", count); end
      wb_valid = 3'b100; wb_id[10 +: 5] = 5'd0; wb_value[64 +: 32] = 32'd1;
      tick();
      wb_valid = '0;
      tick();
      vectors++; if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || pred_addr !== 32'h40) begin errors++; $display("[TB] FAIL branch_pred: v=%b taken=%b pc=%h want 1 1 00000040", pred_valid, pred_taken, pred_addr); end
      vectors++; if (flush !== 1'b1 || redirect_addr !== 32'h100 || count !== 6'd4) begin errors++; $display("[TB] FAIL branch_flush: flush=%b redir=%h count=%0d want 1 00000100 4", flush, redirect_addr, count); end
      applyStimulus(T_REG, 5'd7, 32'h1, 1'b1, 32'd0, 32'd0, 1'b0);
      tick();
      dec_valid = 1'b0;
      vectors++; if (empty !== 1'b1 || count !== 6'd0 || flush !== 1'b0 || pred_valid !== 1'b0 || alloc_id !== 5'd0) begin errors++; $display("[TB] FAIL post_flush: empty=%b count=%0d flush=%b pred=%b alloc=%0d want 1 0 0 0 0", empty, count, flush, pred_valid, alloc_id); end
   endtask

   // Correct and mispredicted JALR
   task automatic test_jalr();
      doReset();
      applyStimulus(T_JALR, 5'd1, 32'h300, 1'b1, 32'h200, 32'h300, 1'b0);
      tick();
      applyStimulus(T_JALR, 5'd2, 32'h500, 1'b1, 32'h300, 32'h300, 1'b0);
      tick();
      dec_valid = 1'b0;
      vectors++; if (rf_valid !== 1'b1 || rf_value !== 32'h204 || rf_rd !== 5'd1 || flush !== 1'b0) begin errors++; $display("[TB] FAIL jalr_hit: v=%b val=%h rd=%0d flush=%b want 1 00000204 1 0", rf_valid, rf_value, rf_rd, flush); end
      tick();
      vectors++; if (rf_valid !== 1'b1 || rf_value !== 32'h304 || flush !== 1'b1 || redirect_addr !== 32'h500) begin errors++; $display("[TB] FAIL jalr_miss: v=%b val=%h flush=%b redir=%h want 1 00000304 1 00000500", rf_valid, rf_value, flush, redirect_addr); end
      tick();
      vectors++; if (empty !== 1'b1 || flush !== 1'b0) begin errors++; $display("[TB] FAIL jalr_flush_clear: empty=%b flush=%b want 1 0", empty, flush); end
   endtask

   // EXIT halts commit permanently until reset
   task automatic test_exit_halt();
      doReset();
      applyStimulus(T_EXIT, 5'd0, 32'd0, 1'b1, 32'd0, 32'd0, 1'b0);
      tick();
      applyStimulus(T_REG, 5'd4, 32'h77, 1'b1, 32'd4, 32'd0, 1'b0);
      tick();
      dec_valid = 1'b0;
      vectors++; if (halt !== 1'b1 || count !== 6'd1) begin errors++; $display("[TB] FAIL exit_halt: halt=%b count=%0d want 1 1", halt, count); end
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++; if (halt !== 1'b1 || rf_valid !== 1'b0 || count !== 6'd1) begin errors++; $display("[TB] FAIL halt_sticky: cycle=%0d halt=%b rf=%b count=%0d want 1 0 1", c, halt, rf_valid, count); end
      end
      doReset();
      vectors++; if (halt !== 1'b0 || count !== 6'd0) begin errors++; $display("[TB] FAIL halt_reset: halt=%b count=%0d want 0 0", halt, count); end
   endtask

   // rdy_in low freezes allocation and commit
   task automatic test_stall();
      doReset();
      rdy_in = 1'b0;
      applyStimulus(T_REG, 5'd6, 32'h99, 1'b1, 32'd0, 32'd0, 1'b0);
      tick();
      tick();
      vectors++; if (count !== 6'd0 || alloc_id !== 5'd0) begin errors++; $display("[TB] FAIL stall_frozen: count=%0d alloc=%0d want 0 0", count, alloc_id); end
      rdy_in = 1'b1;
      tick();
      dec_valid = 1'b0;
      vectors++; if (count !== 6'd1) begin errors++; $display("[TB] FAIL stall_release: count=%0d want 1", count); end
      tick();
      vectors++; if (rf_valid !== 1'b1 || rf_value !== 32'h99 || rf_rd !== 5'd6) begin errors++; $display("[TB] FAIL stall_commit: v=%b val=%h rd=%0d want 1 00000099 6", rf_valid, rf_value, rf_rd); end
   endtask

   initial begin
      test_reset();
      test_fill_and_writeback();
      test_store_handshake();
      test_back_to_back();
      test_branch_flush();
      test_jalr();
      test_exit_halt();
      test_stall();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/rob_multiport.md
# rob_multiport

Parametrised reorder buffer, the successor to the single-writeback ROB. It sits between the decoder, the execution units (ALU, LSB, memory) and the commit targets (register file, memory store port, branch predictor, instruction fetch). Depth and writeback-port count are parameters. The block adds a true full flag, operand query ports with same-cycle bypass, a valid/ready store-commit handshake, and a sticky halt.

## Interface
- DEPTH, 32: number of entries; power of two, ≥4. IDX_W = log2(DEPTH) is a derived localparam.
- NUM_WB, 3: number of writeback channels.
- XLEN, 32: data and address width.
- REG_W, 5: architectural register index width.
- clk_in  in  1  clock (single clock domain)
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  global enable; when low, state is frozen
- dec_valid  in  1  allocate one entry this cycle
- dec_type  in  3  REG / JALR / SB / SH / SW / BRANCH / EXIT
- dec_dest  in  REG_W  destination register
- dec_value  in  XLEN  initial value
- dec_done  in  1  entry is complete at issue (LUI, AUIPC, JAL)
- dec_instr_addr, dec_pred_addr  in  XLEN  instruction PC; predicted target
- dec_pred_taken  in  1  predicted branch direction
- alloc_id  out  IDX_W  id the next allocation receives (the tail)
- full, empty  out  1  occupancy flags
- count  out  IDX_W+1  occupancy
- wb_valid  in  NUM_WB  writeback strobes
- wb_id  in  NUM_WB*IDX_W  flattened entry ids, channel k at bits [k*IDX_W +: IDX_W]
- wb_value, wb_addr  in  NUM_WB*XLEN  flattened result / store address
- qry_id0, qry_id1  in  IDX_W  operand lookup ids
- qry_done0/1  out  1  lookup result is available
- qry_value0/1  out  XLEN  lookup value (combinational)
- rf_valid  out  1  register-file commit pulse
- rf_rd  out  REG_W  committed destination register
- rf_value  out  XLEN  committed value
- rf_id  out  IDX_W  committed entry id
- st_valid  out  1  store request; held until accepted
- st_ready  in  1  memory accepts the store
- st_type  out  2  byte / half / word
- st_addr, st_data  out  XLEN  store address and data
- pred_valid  out  1  predictor update pulse
- pred_addr  out  XLEN  branch PC
- pred_taken  out  1  resolved direction
- flush  out  1  pipeline flush pulse
- redirect_addr  out  XLEN  fetch redirect target
- halt  out  1  sticky halt

## Operation
- **Queue.** Circular queue with head, tail (IDX_W bits, wrap naturally) and count.
  - full = (count == DEPTH); all DEPTH entries are usable. empty = (count == 0).
- **Allocate.** dec_valid && !full writes the entry at tail and sets busy=1, done=dec_done. tail+1 and count+1 take effect at the next edge.
  - dec_valid while full is ignored; the bench asserts on it.
- **Writeback.** Channel k writes value (and addr for stores) and sets done on entry wb_id[k].
  - Two channels targeting the same id: the highest k wins.
  - Writeback to a non-busy entry is ignored.
- **Query.** qry_done = entry done OR any wb_valid with a matching id this cycle; the bypassed value uses the same priority rule.
- **Commit.** At most one per cycle, from head, only when head is done and halt=0. All commit outputs are registered.
  - REG: rf pulse, then retire.
  - JALR: rf pulse with instr_addr+4. If value ≠ pred_addr, also flush with redirect_addr = value.
  - SB/SH/SW: raise st_valid with st_addr/st_data/st_type and hold them while st_ready=0. The entry retires at the edge where st_valid && st_ready; st_valid drops on the next edge unless the new head is another done store.
  - BRANCH: pred pulse with pred_taken = value[0]. If value[0] ≠ pred_taken, flush with redirect_addr = taken ? pred_addr : instr_addr+4.
  - EXIT: halt<=1 and retire; halt is sticky until reset, and no further commits occur.
- **Flush.** In the cycle flush=1, allocation, writeback and commit are ignored. At the next edge head=tail=count=0, all busy bits clear and flush returns to 0.
- **Simultaneous allocate and retire:** count is unchanged.

## Timing
- Reset values:
  - all pulses (rf_valid, pred_valid, flush) = 0
  - st_valid = 0, halt = 0, count = 0, empty = 1, full = 0, alloc_id = 0
  - all data outputs = 0
- Writeback at edge N → earliest rf_valid at edge N+1.
- dec_done entry allocated at edge N → commit at edge N+1 if it is at head.
- Pulses are high for exactly one cycle.
- rdy_in=0: state frozen; rf_valid/pred_valid/flush forced to 0; st_valid and its payload are held.
- Reset mid-store: st_valid drops at the reset edge, and the store is lost by design.

## Structure
- Shared const header holds the ROB type encodings, the store-type encodings and default DEPTH/NUM_WB.
- Sub-module rob_wb_select: a combinational priority match of NUM_WB channels against one id, returning hit plus value. Instantiated per query port and used for write priority.

## Test plan
- Fill: 32 allocations with dec_valid held → full=1 after the 32nd, count=32, the 33rd is ignored, alloc_id wraps to 0 after retirement.
- Channels 0 and 2 write id 5 in the same cycle with 0x11 / 0x22 → entry 5 holds 0x22; qry_id0=5 returns done=1, 0x22 in that same cycle.
- REG at head, written back at edge N with 0xABCD → rf_valid=1, rf_value=0xABCD at edge N+1, count-1.
- SW at head with st_ready held 0 for 3 cycles → st_valid stays 1 with stable payload, no retire; after st_ready=1 for one edge the entry retires.
- Mispredicted BRANCH (pred_taken=0, resolved 1, pred_addr=0x100) with 4 younger entries → pred pulse plus flush=1, redirect_addr=0x100; next cycle empty=1.
- EXIT followed by a done REG → halt=1 stays high, the REG never commits; rst_in clears halt.
